johnson_seq_ctrl: RTL and testbench

JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

---
 rtl/johnson_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : johnson_seq_ctrl                                              |
// | Brief    : N-stage Johnson sequencer with lap counting, pause and abort. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module johnson_seq_ctrl #(
  parameter int N      = 4,
  parameter int LAPS_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LAPS_W-1:0] laps,
  input  logic              dir,
  input  logic              hold,
  input  logic              stop,
  output logic [N-1:0]      q,
  output logic [IDX_W-1:0]  idx,
  output logic              busy,
  output logic              lap_tick,
  output logic              done,
  output logic [LAPS_W-1:0] laps_left
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(2 * N - 1);

  state_t              r_state;
  logic [N-1:0]        r_q;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy;
  logic                r_lap_tick;
  logic                r_done;
  logic [LAPS_W-1:0]   r_laps_left;
  logic                r_dir;

  state_t              w_state_nxt;
  logic [N-1:0]        w_q_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_lap_tick_nxt;
  logic                w_done_nxt;
  logic [LAPS_W-1:0]   w_laps_left_nxt;
  logic                w_dir_nxt;
  logic [N-1:0]        w_q_step;
  logic [IDX_W-1:0]    w_idx_step;

  // One step in the latched direction; idx wraps explicitly since 2N may not be a power of two.
  always_comb begin
    if (r_dir) begin
      w_q_step   = {r_q[N-2:0], ~r_q[N-1]};
      w_idx_step = (r_idx == '0) ? c_LAST_IDX : r_idx - IDX_W'(1);
    end else begin
      w_q_step   = {~r_q[0], r_q[N-1:1]};
      w_idx_step = (r_idx == c_LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_q_nxt         = r_q;
    w_idx_nxt       = r_idx;
    w_lap_tick_nxt  = 1'b0;
    w_done_nxt      = 1'b0;
    w_laps_left_nxt = r_laps_left;
    w_dir_nxt       = r_dir;

    unique case (r_state)
      S_IDLE: begin
        w_q_nxt         = '0;
        w_idx_nxt       = '0;
        w_laps_left_nxt = '0;
        if (start && !stop) begin
          w_state_nxt     = S_RUN;
          w_laps_left_nxt = laps;
          w_dir_nxt       = dir;
        end
      end

      S_RUN: begin
        if (stop) begin
          w_state_nxt     = S_IDLE;
          w_q_nxt         = '0;
          w_idx_nxt       = '0;
          w_laps_left_nxt = '0;
        end else if (hold) begin
          w_state_nxt = S_PAUSE;
        end else begin
          w_q_nxt   = w_q_step;
          w_idx_nxt = w_idx_step;
          // laps_left of zero marks a continuous run that never completes.
          if (w_q_step == '0) begin
            w_lap_tick_nxt = 1'b1;
            if (r_laps_left == LAPS_W'(1)) begin
              w_state_nxt     = S_DONE;
              w_done_nxt      = 1'b1;
              w_laps_left_nxt = '0;
            end else if (r_laps_left != '0) begin
              w_laps_left_nxt = r_laps_left - LAPS_W'(1);
            end
          end
        end
      end

      S_PAUSE: begin
        if (stop) begin
          w_state_nxt     = S_IDLE;
          w_q_nxt         = '0;
          w_idx_nxt       = '0;
          w_laps_left_nxt = '0;
        end else if (!hold) begin
          w_state_nxt = S_RUN;
        end
      end

      S_DONE: begin
        w_state_nxt     = S_IDLE;
        w_q_nxt         = '0;
        w_idx_nxt       = '0;
        w_laps_left_nxt = '0;
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_q_nxt         = '0;
        w_idx_nxt       = '0;
        w_laps_left_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_lap_tick  <= 1'b0;
      r_done      <= 1'b0;
      r_laps_left <= '0;
      r_dir       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_q         <= w_q_nxt;
      r_idx       <= w_idx_nxt;
      r_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
      r_lap_tick  <= w_lap_tick_nxt;
      r_done      <= w_done_nxt;
      r_laps_left <= w_laps_left_nxt;
      r_dir       <= w_dir_nxt;
    end
  end

  assign q         = r_q;
  assign idx       = r_idx;
  assign busy      = r_busy;
  assign lap_tick  = r_lap_tick;
  assign done      = r_done;
  assign laps_left = r_laps_left;

endmodule
`default_nettype wire

// File: tb/tb_johnson_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_johnson_seq_ctrl                                           |
// | Brief    : Directed and random checks of johnson_seq_ctrl vs step model. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_johnson_seq_ctrl;
  localparam int N      = 4;
  localparam int LAPS_W = 8;
  localparam int IDX_W  = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [LAPS_W-1:0] laps = '0;
  logic              dir = 1'b0;
  logic              hold = 1'b0;
  logic              stop = 1'b0;
  logic [N-1:0]      q;
  logic [IDX_W-1:0]  idx;
  logic              busy;
  logic              lap_tick;
  logic              done;
  logic [LAPS_W-1:0] laps_left;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a run is just a count of steps taken; everything else is arithmetic on it.
  int m_mode = M_IDLE;
  int m_steps = 0;
  int m_laps = 0;
  int m_dir = 0;
  bit m_tick = 0;
  bit m_done = 0;

  johnson_seq_ctrl #(.N(N), .LAPS_W(LAPS_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .laps(laps), .dir(dir),
    .hold(hold), .stop(stop), .q(q), .idx(idx), .busy(busy),
    .lap_tick(lap_tick), .done(done), .laps_left(laps_left)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed running, required finished)");
    $fatal(1, "watchdog");
  end

  function automatic int exp_phase();
    int r;
    r = m_steps % (2 * N);
    if (m_dir != 0 && r != 0) return 2 * N - r;
    return r;
  endfunction

  // Forward position p: the first p stages are ones up to N, then ones drain from the top.
  function automatic logic [N-1:0] johnson_of(input int p);
    logic [N-1:0] v;
    v = '0;
    for (int b = 0; b < N; b++) begin
      if (p <= N) v[b] = (b >= N - p);
      else        v[b] = (b < 2 * N - p);
    end
    return v;
  endfunction

  function automatic int exp_left();
    if ((m_mode == M_RUN || m_mode == M_PAUSE) && m_laps != 0)
      return m_laps - m_steps / (2 * N);
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_steps = 0; m_laps = 0; m_dir = 0; m_tick = 0; m_done = 0;
  endtask

  task automatic model_step();
    m_tick = 0;
    m_done = 0;
    case (m_mode)
      M_IDLE: if (start && !stop) begin
        m_mode = M_RUN; m_laps = int'(laps); m_dir = int'(dir); m_steps = 0;
      end
      M_RUN, M_PAUSE: begin
        if (stop) begin
          m_mode = M_IDLE; m_steps = 0;
        end else if (hold) begin
          m_mode = M_PAUSE;
        end else if (m_mode == M_PAUSE) begin
          m_mode = M_RUN;
        end else begin
          m_steps++;
          if (m_steps % (2 * N) == 0) m_tick = 1;
          if (m_laps != 0 && m_steps == 2 * N * m_laps) begin
            m_mode = M_DONE; m_done = 1;
          end
        end
      end
      default: begin
        m_mode = M_IDLE; m_steps = 0;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    chk("q", 32'(q), 32'(johnson_of(exp_phase())));
    chk("idx", 32'(idx), 32'(exp_phase()));
    chk("busy", 32'(busy), 32'(m_mode == M_RUN || m_mode == M_PAUSE));
    chk("lap_tick", 32'(lap_tick), 32'(m_tick));
    chk("done", 32'(done), 32'(m_done));
    chk("laps_left", 32'(laps_left), 32'(exp_left()));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic run_until_done(input int max_edges, output int n);
    n = -1;
    for (int i = 1; i <= max_edges; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int ticks;
    int dones;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();

    // Forward, two laps: done 16 edges after the start edge
    laps = 8'd2; dir = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done(40, n);
    chk("fwd2_done_latency", 32'(n), 32'd16);
    tick();

    // Reverse, one lap
    laps = 8'd1; dir = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done(40, n);
    chk("rev1_done_latency", 32'(n), 32'd8);
    tick();

    // Hold three cycles at 1100: done delayed by four edges
    laps = 8'd1; dir = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("hold_at_1100", 32'(q), 32'(4'b1100));
    hold = 1'b1;
    tick(); tick(); tick();
    hold = 1'b0;
    run_until_done(40, n);
    chk("hold_done_latency", 32'(n + 5), 32'd12);
    tick();

    // Continuous run, 20 steps, then stop
    laps = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    ticks = 0; dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ticks += int'(lap_tick);
      dones += int'(done);
    end
    chk("cont_lap_ticks", 32'(ticks), 32'd2);
    chk("cont_no_done", 32'(dones), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_q", 32'(q), 32'd0);

    // Asynchronous reset between edges at 1110
    laps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_reset_q", 32'(q), 32'(4'b1110));
    #1 reset = 1'b1;
    #1 model_reset();
    check_all();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done(40, n);
    chk("post_reset_done_latency", 32'(n), 32'd8);
    tick();

    // Simultaneous commands
    start = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0; laps = 8'd3; dir = 1'b0;
    tick();
    laps = 8'd1; dir = 1'b1;
    tick(); tick();
    start = 1'b0; stop = 1'b1; hold = 1'b1;
    tick();
    stop = 1'b0; hold = 1'b0;
    chk("stop_hold_busy", 32'(busy), 32'd0);
    start = 1'b1; laps = 8'd1; dir = 1'b0;
    tick();
    run_until_done(40, n);
    chk("busy_start_ignored_latency", 32'(n), 32'd8);
    tick();
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      start = ($urandom % 4) == 0;
      laps  = LAPS_W'($urandom % 3);
      dir   = 1'($urandom % 2);
      hold  = ($urandom % 5) == 0;
      stop  = ($urandom % 40) == 0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
